puf_key_builder: RTL and testbench
==================================

PUF_KEY_BUILDER -- requirements
Module: puf_key_builder

Interface
REQ-001 Parameter VOTES, default 5, number of PUF evaluations per response word; SHALL be odd, range 1..7.
REQ-002 Parameter WORDS, default 8, number of 16-bit words assembled into the key (8 x 16 = 128).
REQ-003 Parameter CHAL_BASE, default 16'hA5C3, base challenge value.
REQ-004 Parameter TIMEOUT, default 1023, maximum number of clk cycles to wait for puf_finish.
REQ-005 clk  in  1  system clock.
REQ-006 Reset  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle pulse that requests key generation.
REQ-008 puf_finish  in  1  level input from the RO PUF; high when the response is complete.
REQ-009 puf_resp  in  16  RO PUF response word.
REQ-010 puf_rst  out  1  active-high reset to the RO PUF, one evaluation per pulse.
REQ-011 puf_challenge  out  16  challenge presented to the PUF.
REQ-012 key  out  128  voted key; word 0 in key[127:112], word w in key[127-16w -: 16].
REQ-013 key_valid  out  1  high while key holds a complete result.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 err  out  1  sticky timeout flag; cleared by the next accepted start.
REQ-016 unstable_cnt  out  8  count of non-unanimous bit votes; saturates at 255.

Function
REQ-017 FSM states: IDLE, ARM, WAIT, ACCUM, NEXT, DONE.
REQ-018 IDLE/DONE + start: clear key_valid, err, unstable_cnt, word index w, vote index v, and vote counters; go to ARM.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 ARM lasts exactly 1 cycle with puf_rst=1, then goes to WAIT; puf_rst=0 in all other states.
REQ-021 puf_challenge = CHAL_BASE rotated left by 2*w bits; held stable from ARM through ACCUM for word w.
REQ-022 WAIT: puf_finish is ignored in the first cycle after ARM (stale level).
REQ-023 WAIT: from the second cycle on, puf_finish=1 moves to ACCUM; the timeout counter increments each WAIT cycle.
REQ-024 Timeout counter reaching TIMEOUT: set err=1 and go to IDLE; key_valid stays 0 and key is left unchanged.
REQ-025 ACCUM (1 cycle): for each bit i, cnt[i] += puf_resp[i] (3-bit counters); v increments.
- If v < VOTES after the increment: go to ARM.
- Otherwise: go to NEXT.
REQ-026 NEXT (1 cycle): majority bit i = (cnt[i] > VOTES/2).
- Write the word into the key slot for w.
- Add to unstable_cnt (saturating) the number of bits with 0 < cnt[i] < VOTES.
- Clear cnt and v.
- If w = WORDS-1: go to DONE. Otherwise: w++, go to ARM.
REQ-027 DONE: key_valid=1, key held; new start restarts per REQ-018.
REQ-028 Total latency with an ideal PUF finishing F cycles after puf_rst = WORDS*(VOTES*(F+2)+1)+1 cycles from start to key_valid.

Reset
REQ-029 Reset=1 SHALL asynchronously force:
- state IDLE;
- key=0, key_valid=0, busy=0, err=0, unstable_cnt=0;
- puf_rst=1 while Reset is asserted, 0 after release;
- puf_challenge=CHAL_BASE;
- all counters = 0.
REQ-030 Reset mid-generation discards partial words; no partial key is ever visible with key_valid=1.

Structure
REQ-031 Shared package puf_pkg: FSM state encoding, default CHAL_BASE, and the 16-bit word/128-bit key width constants.
REQ-032 One sub-module, puf_vote_bank: 16 x 3-bit vote counters with clear, accumulate, and majority/unanimity outputs.

Verification
REQ-033 Bench SHALL use a behavioural PUF model with puf_finish rising F=512 cycles after puf_rst falls; PUF response = f(challenge).
REQ-034 Stable PUF returning challenge^16'hFFFF, start pulse:
- key word w = rotl(16'hA5C3, 2w)^16'hFFFF;
- unstable_cnt=0;
- key_valid after the REQ-028 count.
REQ-035 Word 0 response flips bit 0 in 2 of 5 evaluations:
- majority value kept;
- unstable_cnt=1.
REQ-036 Model never raises puf_finish:
- err=1 after 1023 WAIT cycles;
- state IDLE, key_valid=0.
- A following start clears err.
REQ-037 start pulsed again mid-generation:
- ignored;
- completion time unchanged.
REQ-038 Reset asserted during word 3:
- all outputs at reset values immediately;
- after release and start, the full correct key is produced.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the RO-PUF key builder.
// Contents: FSM state encoding, default base challenge, word/key widths,
// and small helpers (16-bit rotate-left, 16-bit population count).
package puf_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned KEY_W  = 128;

    localparam logic [WORD_W-1:0] CHAL_BASE_DEF = 16'hA5C3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_ACCUM = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Rotate a 16-bit word left by n bits.
    function automatic logic [WORD_W-1:0] rotl16(input logic [WORD_W-1:0] x,
                                                 input logic [3:0] n);
        logic [2*WORD_W-1:0] d;
        d = {x, x} << n;
        return d[2*WORD_W-1:WORD_W];
    endfunction

    // Number of set bits in a 16-bit word.
    function automatic logic [4:0] popcount16(input logic [WORD_W-1:0] x);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < WORD_W; i++) begin
            s = s + 5'(x[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/puf_vote_bank.sv
// Sixteen 3-bit vote counters, one per response bit.
// Ports:
//   clk, Reset   - clock, asynchronous active-high reset
//   i_clr        - clear all counters (takes priority over i_acc)
//   i_acc        - add i_resp bit i into counter i
//   i_resp       - PUF response word being voted
//   o_maj_c      - per-bit majority (count > VOTES/2), decoded from counters
//   o_mixed_c    - per-bit non-unanimous flag (0 < count < VOTES)
module puf_vote_bank
    import puf_pkg::*;
#(
    parameter int unsigned VOTES = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              i_clr,
    input  logic              i_acc,
    input  logic [WORD_W-1:0] i_resp,
    output logic [WORD_W-1:0] o_maj_c,
    output logic [WORD_W-1:0] o_mixed_c
);

    logic [WORD_W-1:0][2:0] r_cnt;

    // Vote counters.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_acc) begin
            for (int i = 0; i < WORD_W; i++) begin
                r_cnt[i] <= r_cnt[i] + 3'(i_resp[i]);
            end
        end
    end

    // Majority and unanimity decode.
    always_comb begin
        for (int i = 0; i < WORD_W; i++) begin
            o_maj_c[i]   = (r_cnt[i] > 3'(VOTES / 2));
            o_mixed_c[i] = (r_cnt[i] != 3'd0) && (r_cnt[i] != 3'(VOTES));
        end
    end

endmodule

// File: rtl/puf_key_builder.sv
// Builds a key from an RO PUF by majority-voting VOTES evaluations per
// 16-bit word, for WORDS words, each with its own rotated challenge.
// Ports:
//   clk, Reset     - clock, asynchronous active-high reset
//   start          - one-cycle request; ignored while busy
//   puf_finish     - PUF response-complete level
//   puf_resp       - PUF response word
//   puf_rst        - one-cycle PUF reset per evaluation (high during Reset)
//   puf_challenge  - CHAL_BASE rotated left by 2*word_index
//   key            - voted key, word 0 in the most significant slot
//   key_valid      - key holds a complete result
//   busy           - generation in progress
//   err            - sticky timeout flag
//   unstable_cnt   - saturating count of non-unanimous bit votes
module puf_key_builder
    import puf_pkg::*;
#(
    parameter int unsigned       VOTES     = 5,
    parameter int unsigned       WORDS     = 8,
    parameter logic [WORD_W-1:0] CHAL_BASE = CHAL_BASE_DEF,
    parameter int unsigned       TIMEOUT   = 1023
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      puf_finish,
    input  logic [WORD_W-1:0]         puf_resp,
    output logic                      puf_rst,
    output logic [WORD_W-1:0]         puf_challenge,
    output logic [WORDS*WORD_W-1:0]   key,
    output logic                      key_valid,
    output logic                      busy,
    output logic                      err,
    output logic [7:0]                unstable_cnt
);

    localparam int unsigned WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned KW    = WORDS * WORD_W;

    state_t              r_state, w_state_nxt;
    logic [WW-1:0]       r_w, w_w_nxt;
    logic [2:0]          r_v, w_v_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic [KW-1:0]       r_key, w_key_nxt;
    logic                r_key_valid, w_key_valid_nxt;
    logic                r_err, w_err_nxt;
    logic [7:0]          r_unstable, w_unstable_nxt;
    logic                r_puf_rst, w_puf_rst_nxt;
    logic                r_busy, w_busy_nxt;
    logic [WORD_W-1:0]   r_chal, w_chal_nxt;
    logic                w_clr, w_acc;
    logic [WORD_W-1:0]   w_maj, w_mixed;
    logic [8:0]          w_unst_sum;

    puf_vote_bank #(.VOTES(VOTES)) u_vote_bank (
        .clk       (clk),
        .Reset     (Reset),
        .i_clr     (w_clr),
        .i_acc     (w_acc),
        .i_resp    (puf_resp),
        .o_maj_c   (w_maj),
        .o_mixed_c (w_mixed)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_v         <= '0;
            r_tmo       <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            r_unstable  <= '0;
            r_puf_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_chal      <= CHAL_BASE;
        end else begin
            r_state     <= w_state_nxt;
            r_w         <= w_w_nxt;
            r_v         <= w_v_nxt;
            r_tmo       <= w_tmo_nxt;
            r_key       <= w_key_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_err       <= w_err_nxt;
            r_unstable  <= w_unstable_nxt;
            r_puf_rst   <= w_puf_rst_nxt;
            r_busy      <= w_busy_nxt;
            r_chal      <= w_chal_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_w_nxt         = r_w;
        w_v_nxt         = r_v;
        w_tmo_nxt       = r_tmo;
        w_key_nxt       = r_key;
        w_key_valid_nxt = r_key_valid;
        w_err_nxt       = r_err;
        w_unstable_nxt  = r_unstable;
        w_clr           = 1'b0;
        w_acc           = 1'b0;
        w_unst_sum      = {1'b0, r_unstable} + 9'(popcount16(w_mixed));

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_ARM;
                    w_key_valid_nxt = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_unstable_nxt  = '0;
                    w_w_nxt         = '0;
                    w_v_nxt         = '0;
                    w_tmo_nxt       = '0;
                    w_clr           = 1'b1;
                end
            end
            S_ARM: begin
                w_state_nxt = S_WAIT;
                w_tmo_nxt   = '0;
            end
            S_WAIT: begin
                // First WAIT cycle still sees the previous evaluation's finish level.
                if ((r_tmo != '0) && puf_finish) begin
                    w_state_nxt = S_ACCUM;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            S_ACCUM: begin
                w_acc   = 1'b1;
                w_v_nxt = r_v + 3'd1;
                if (w_v_nxt < 3'(VOTES)) begin
                    w_state_nxt = S_ARM;
                end else begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                for (int k = 0; k < WORDS; k++) begin
                    if (r_w == WW'(k)) begin
                        w_key_nxt[(WORDS-1-k)*WORD_W +: WORD_W] = w_maj;
                    end
                end
                w_unstable_nxt = (w_unst_sum > 9'd255) ? 8'hFF : w_unst_sum[7:0];
                w_clr          = 1'b1;
                w_v_nxt        = '0;
                if (r_w == WW'(WORDS - 1)) begin
                    w_state_nxt     = S_DONE;
                    w_key_valid_nxt = 1'b1;
                end else begin
                    w_w_nxt     = r_w + 1'b1;
                    w_state_nxt = S_ARM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_puf_rst_nxt = (w_state_nxt == S_ARM);
        w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_chal_nxt    = rotl16(CHAL_BASE, 4'({w_w_nxt, 1'b0}));
    end

    assign puf_rst       = r_puf_rst;
    assign puf_challenge = r_chal;
    assign key           = r_key;
    assign key_valid     = r_key_valid;
    assign busy          = r_busy;
    assign err           = r_err;
    assign unstable_cnt  = r_unstable;

endmodule

// File: tb/tb_puf_key_builder.sv
// Directed bench for puf_key_builder with a behavioural RO PUF model.
// The PUF returns ~challenge, raises finish F cycles after puf_rst falls,
// and can optionally flip bit 0 on selected word-0 evaluations or never finish.
module tb_puf_key_builder;
    import puf_pkg::*;

    localparam int unsigned F     = 512;
    localparam int unsigned LAT   = 8 * (5 * (F + 2) + 1) + 1;  // 20569
    localparam int unsigned LIMIT = 30000;
    localparam logic [KEY_W-1:0] EXP_KEY =
        128'h5A3C_68F1_A3C5_8F16_3C5A_F168_C5A3_168F;

    logic              clk = 1'b0;
    logic              Reset;
    logic              start;
    logic              puf_finish;
    logic [WORD_W-1:0] puf_resp;
    logic              puf_rst;
    logic [WORD_W-1:0] puf_challenge;
    logic [KEY_W-1:0]  key;
    logic              key_valid;
    logic              busy;
    logic              err;
    logic [7:0]        unstable_cnt;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic        model_en;
    logic        flip_mode;
    int unsigned mcnt;
    int unsigned eval_cnt;
    logic        flip_now;

    puf_key_builder dut (
        .clk           (clk),
        .Reset         (Reset),
        .start         (start),
        .puf_finish    (puf_finish),
        .puf_resp      (puf_resp),
        .puf_rst       (puf_rst),
        .puf_challenge (puf_challenge),
        .key           (key),
        .key_valid     (key_valid),
        .busy          (busy),
        .err           (err),
        .unstable_cnt  (unstable_cnt)
    );

    always #5 clk = ~clk;

    // PUF model: finish is seen high in the F-th cycle after puf_rst falls.
    always @(posedge clk) begin
        if (puf_rst) begin
            mcnt       <= 1;
            puf_finish <= 1'b0;
        end else begin
            if (mcnt < F) mcnt <= mcnt + 1;
            puf_finish <= model_en && (mcnt >= F - 1);
        end
        if (!flip_mode) eval_cnt <= 0;
        else if (puf_rst && (puf_challenge == 16'hA5C3)) eval_cnt <= eval_cnt + 1;
    end

    assign flip_now = flip_mode && (puf_challenge == 16'hA5C3) &&
                      ((eval_cnt == 2) || (eval_cnt == 4));
    assign puf_resp = ~puf_challenge ^ {15'b0, flip_now};

    task automatic check(input string tag, input logic [KEY_W-1:0] obs,
                         input logic [KEY_W-1:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_key"},      key,                  '0);
        check({tag, "_kvalid"},   128'(key_valid),      128'd0);
        check({tag, "_busy"},     128'(busy),           128'd0);
        check({tag, "_err"},      128'(err),            128'd0);
        check({tag, "_unstable"}, 128'(unstable_cnt),   128'd0);
        check({tag, "_puf_rst"},  128'(puf_rst),        128'd1);
        check({tag, "_chal"},     128'(puf_challenge),  128'h A5C3);
    endtask

    // Pulse start, count edges from the accepting edge until key_valid.
    task automatic start_and_wait(input bit mid_start, output int unsigned cyc,
                                  output logic kv_after_start);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        start = 1'b0;
        kv_after_start = key_valid;
        while (!key_valid && cyc < LIMIT) begin
            @(posedge clk);
            cyc++;
            #1;
            start = (mid_start && (cyc == 3000 || cyc == 12000)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        int unsigned cyc;
        int unsigned n;
        logic        kv0;

        Reset     = 1'b1;
        start     = 1'b0;
        model_en  = 1'b1;
        flip_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");

        @(negedge clk);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        check("puf_rst_release", 128'(puf_rst), 128'd0);

        // Reset during word 3.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (puf_challenge !== 16'h70E9 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("word3_chal", 128'(puf_challenge), 128'h70E9);
        repeat (100) @(posedge clk);
        #3;
        check("word3_busy", 128'(busy), 128'd1);
        check("word3_partial_key_w0", 128'(key[127:112]), 128'h5A3C);
        Reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        Reset = 1'b0;

        // Stable PUF, full run.
        start_and_wait(1'b0, cyc, kv0);
        check("stable_latency", 128'(cyc), 128'(LAT));
        check("stable_kvalid", 128'(key_valid), 128'd1);
        check("stable_key", key, EXP_KEY);
        check("stable_unstable", 128'(unstable_cnt), 128'd0);
        @(negedge clk);
        check("done_busy", 128'(busy), 128'd0);
        check("done_err", 128'(err), 128'd0);

        // Word 0 bit 0 flipped in 2 of 5 evaluations, extra start pulses mid-run.
        flip_mode = 1'b1;
        start_and_wait(1'b1, cyc, kv0);
        check("restart_clears_kvalid", 128'(kv0), 128'd0);
        check("flip_latency", 128'(cyc), 128'(LAT));
        check("flip_key", key, EXP_KEY);
        check("flip_unstable", 128'(unstable_cnt), 128'd1);
        flip_mode = 1'b0;

        // PUF never finishes: timeout.
        model_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        start = 1'b0;
        while (!err && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("tmo_err", 128'(err), 128'd1);
        check("tmo_cycles", 128'(cyc), 128'd1025);
        check("tmo_busy", 128'(busy), 128'd0);
        check("tmo_kvalid", 128'(key_valid), 128'd0);
        check("tmo_key_kept", key, EXP_KEY);

        // Next start clears err.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_clears_err", 128'(err), 128'd0);
        check("start_sets_busy", 128'(busy), 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
